// File: rtl/rr_arbiter_4.sv
// rr_arbiter_4: round-robin arbiter that shares one resource among four
// requesters, with registered owner index/enable and a decoded one-hot grant.
//
// Ports:
//   clk      in   1  rising-edge clock
//   rst      in   1  synchronous active-high reset
//   req      in   4  request vector, req[i] from requester i, level-held
//   gnt      out  4  one-hot grant, zero when idle
//   gnt_idx  out  2  index of current owner, holds last owner when idle
//   gnt_vld  out  1  high while some requester owns the resource
//
// Build option: define ARB_TIMEOUT_EN to bound ownership to MAX_HOLD
// consecutive cycles whenever other requesters are waiting.

module rr_arbiter_4 #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_vld
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [1:0] idx_nxt;
    logic       vld_nxt;
    logic [1:0] last;
    logic [1:0] last_nxt;
    logic [3:0] owner_oh;
    logic [3:0] others;
    logic       timeout;

    // First set bit of mask, scanning from+1, from+2, from+3, from.
    // The scan runs backwards so the earliest position in that order
    // overwrites all later ones.
    function automatic logic [1:0] pick(
        input logic [1:0] from,
        input logic [3:0] mask
    );
        logic [1:0] cand;
        pick = from;
        for (int k = 4; k >= 1; k--) begin
            cand = from + 2'(k);
            if (mask[cand]) begin
                pick = cand;
            end
        end
    endfunction

    assign owner_oh = 4'b0001 << gnt_idx;
    assign others   = req & ~owner_oh;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD - 1);

    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] cnt_nxt;

    // Forced hand-off only when someone else is actually waiting;
    // a lone owner keeps the resource with the counter saturated.
    assign timeout = (hold_cnt == CNT_MAX) && (|others);
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        idx_nxt   = gnt_idx;
        vld_nxt   = gnt_vld;
        last_nxt  = last;
`ifdef ARB_TIMEOUT_EN
        cnt_nxt   = hold_cnt;
`endif
        unique case (state)
            IDLE: begin
                if (|req) begin
                    idx_nxt   = pick(last, req);
                    last_nxt  = pick(last, req);
                    vld_nxt   = 1'b1;
                    state_nxt = GRANT;
`ifdef ARB_TIMEOUT_EN
                    cnt_nxt   = '0;
`endif
                end
            end
            GRANT: begin
                if (req[gnt_idx] && !timeout) begin
`ifdef ARB_TIMEOUT_EN
                    if (hold_cnt != CNT_MAX) begin
                        cnt_nxt = hold_cnt + 1'b1;
                    end
`endif
                end else if (|others) begin
                    // Direct hand-off, no idle bubble between owners.
                    idx_nxt  = pick(gnt_idx, others);
                    last_nxt = pick(gnt_idx, others);
`ifdef ARB_TIMEOUT_EN
                    cnt_nxt  = '0;
`endif
                end else begin
                    vld_nxt   = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                vld_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            gnt_idx <= 2'b00;
            gnt_vld <= 1'b0;
            last    <= 2'b11;
`ifdef ARB_TIMEOUT_EN
            hold_cnt <= '0;
`endif
        end else begin
            state   <= state_nxt;
            gnt_idx <= idx_nxt;
            gnt_vld <= vld_nxt;
            last    <= last_nxt;
`ifdef ARB_TIMEOUT_EN
            hold_cnt <= cnt_nxt;
`endif
        end
    end

    // Decoded from registers only, so req never reaches gnt combinationally.
    assign gnt = gnt_vld ? owner_oh : 4'b0000;

endmodule
